// File: rtl/sobel_sqrt_pkg.sv
// rtl/sobel_sqrt_pkg.sv - shared widths, state encoding and operand prep for the Sobel magnitude-squared stage
package sobel_sqrt_pkg;

    localparam int GRAD_W     = 11;
    localparam int OPND_W     = 8;
    localparam int R_W        = 16;
    localparam int MUL_CYCLES = 8;
    localparam int PROD_W     = 2 * OPND_W;
    localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Floor-shift (arithmetic), magnitude, then clamp into the 8-bit multiplier range.
    function automatic logic [OPND_W-1:0] prep_operand(
        input logic signed [GRAD_W-1:0] g,
        input int                       shift
    );
        logic signed [GRAD_W-1:0] shifted;
        logic signed [GRAD_W:0]   widened;
        logic        [GRAD_W:0]   mag;
        shifted = g >>> shift;
        widened = {shifted[GRAD_W-1], shifted};
        mag     = (widened < 0) ? $unsigned(-widened) : $unsigned(widened);
        if (mag > (GRAD_W + 1)'(2**OPND_W - 1)) begin
            return {OPND_W{1'b1}};
        end
        return mag[OPND_W-1:0];
    endfunction

endpackage

// File: rtl/mag_sq_serial_mult.sv
// rtl/mag_sq_serial_mult.sv - 8x8 shift-add squarer, one multiplier bit per cycle
module mag_sq_serial_mult
    import sobel_sqrt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OPND_W-1:0] operand,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] mcand;
    logic [OPND_W-1:0] mplier;
    logic [PROD_W-1:0] acc;
    logic [CNT_W-1:0]  bit_cnt;
    logic              busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            mcand   <= {{(PROD_W-OPND_W){1'b0}}, operand};
            mplier  <= operand;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(MUL_CYCLES - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    // High during the final step so the controller can leave MUL on that same edge.
    assign done    = busy && (bit_cnt == CNT_W'(MUL_CYCLES - 1));
    assign product = acc;

endmodule

// File: rtl/sobel_mag_sq_gen.sv
// rtl/sobel_mag_sq_gen.sv - serial gx^2+gy^2 radicand generator; MAG_SQ_SAT_EN selects saturation over wrap
module sobel_mag_sq_gen
    import sobel_sqrt_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GRAD_W-1:0] gx,
    input  logic [GRAD_W-1:0] gy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [R_W-1:0]    R
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              load_r;
    logic [OPND_W-1:0] opnd_a;
    logic [OPND_W-1:0] opnd_b;
    logic              done_a;
    logic              done_b;
    logic [PROD_W-1:0] prod_a;
    logic [PROD_W-1:0] prod_b;
    logic [R_W-1:0]    r_next;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign opnd_a   = prep_operand(gx, SHIFT);
    assign opnd_b   = prep_operand(gy, SHIFT);

    mag_sq_serial_mult u_mult_a (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .operand (opnd_a),
        .done    (done_a),
        .product (prod_a)
    );

    mag_sq_serial_mult u_mult_b (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .operand (opnd_b),
        .done    (done_b),
        .product (prod_b)
    );

`ifdef MAG_SQ_SAT_EN
    logic [R_W:0] sum_full;
    assign sum_full = {1'b0, prod_a} + {1'b0, prod_b};
    assign r_next   = sum_full[R_W] ? {R_W{1'b1}} : sum_full[R_W-1:0];
`else
    assign r_next   = prod_a + prod_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_r     = 1'b0;
        case (state)
            IDLE: if (accept) state_next = MUL;
            MUL:  if (done_a && done_b) state_next = SUM;
            SUM: begin
                load_r     = 1'b1;
                state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // R is left untouched on transfer; out_valid alone qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R         <= '0;
            out_valid <= 1'b0;
        end else if (load_r) begin
            R         <= r_next;
            out_valid <= 1'b1;
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sobel_mag_sq_gen.md
SOBEL_MAG_SQ_GEN -- requirements
Module: sobel_mag_sq_gen

Interface
REQ-001 Parameter SHIFT, default 3, meaning arithmetic right-shift applied to each gradient before squaring (legal 0..3).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  gradient pair present.
REQ-005 in_ready  output  1  block can accept a pair.
REQ-006 gx  input  11  signed horizontal Sobel gradient (-1024..1023).
REQ-007 gy  input  11  signed vertical Sobel gradient.
REQ-008 out_valid  output  1  R holds a result.
REQ-009 out_ready  input  1  downstream square-root unit accepts R.
REQ-010 R  output  16  unsigned squared magnitude, the 16-bit radicand for the approximate square-root stage.

Function
REQ-011 States: IDLE, MUL, SUM, DONE; in_ready SHALL be 1 only in IDLE.
REQ-012 Accept on a rising edge with in_valid && in_ready: register gx, gy; state -> MUL; bit counter -> 0.
REQ-013 Operand prep at accept: arithmetic shift right by SHIFT (floor, so -5>>>3 = -1), absolute value, clamp to 255; results a, b are 8-bit unsigned.
REQ-014 MUL: shift-add squaring of a and b in parallel, one multiplier bit per cycle, 8 cycles; after 8th MUL edge state -> SUM.
REQ-015 SUM: compute a^2 + b^2 (17-bit), reduce to 16 bits per REQ-025/026, load R, set out_valid, state -> DONE.
REQ-016 Latency: out_valid SHALL be high exactly 9 rising edges after the accepting edge (8 MUL + 1 SUM).
REQ-017 DONE: R and out_valid held stable until out_valid && out_ready on an edge; then out_valid -> 0, state -> IDLE.
REQ-018 No bypass: in_ready stays 0 in the DONE transfer cycle; minimum interval between accepts is 11 cycles.
REQ-019 gx, gy changes while not in IDLE SHALL have no effect on the result.
REQ-020 in_valid asserted while in_ready = 0 SHALL be ignored (no queuing).
REQ-021 R SHALL retain its last value after transfer; only out_valid qualifies it.

Reset
REQ-022 rst high SHALL immediately force state IDLE, in_ready 1, out_valid 0, R 0x0000, counter 0, internal accumulators 0.
REQ-023 rst asserted mid-MUL/SUM/DONE SHALL discard the in-flight pair; no result is emitted afterwards.
REQ-024 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-025 With MAG_SQ_SAT_EN defined: sums above 65535 SHALL saturate R to 0xFFFF.
REQ-026 Without MAG_SQ_SAT_EN: R SHALL be the sum modulo 2^16 (bit 16 dropped).

Structure
REQ-027 Shared package sobel_sqrt_pkg holds: state enum, GRAD_W = 11, OPND_W = 8, R_W = 16, MUL_CYCLES = 8.
REQ-028 One sub-module mag_sq_serial_mult (8x8 shift-add squarer, start/done), instantiated twice for a and b.

Verification
REQ-029 SHIFT=3, gx=240, gy=0 -> a=30, b=0, R=900, out_valid 9 edges after accept.
REQ-030 SHIFT=3, gx=-1024, gy=-1024 -> a=b=128, R=32768; gx=-5, gy=7 -> a=1, b=0, R=1.
REQ-031 SHIFT=0, gx=300, gy=300 -> clamp 255 each; MAG_SQ_SAT_EN: R=0xFFFF; without: R=64514.
REQ-032 out_ready held 0 for 20 cycles after out_valid -> R and out_valid stable, in_ready 0, new in_valid ignored; out_ready 1 -> transfer, IDLE next edge.
REQ-033 rst pulsed on 4th MUL cycle -> out_valid 0, R 0x0000, in_ready 1 immediately; no stale result emitted later.
REQ-034 Back-to-back pairs with in_valid held high -> accepts exactly 11 cycles apart, results in order.
